bscan_word_bridge: RTL
======================

// Module: bscan_word_bridge
// PURPOSE
//  Word-level bridge between the 32-bit application pipes (toBscan / fromBscan) and a JTAG
//  BSCAN user-DR chain.
//  - Buffers outgoing words in a small FIFO.
//  - Serializes them onto TDO during DR-shift.
//  - Deserializes host words from TDI and presents them on the fromBscan pipe.
//  - JTAG strobes arrive already synchronized to CLK as 1-cycle pulses; the block is single
//    clock domain.
// PARAMETERS
//  WIDTH  32  data word width; DR frame length is WIDTH+1 bits
//  DEPTH  4   tx FIFO depth in words; power of 2, >= 2
// PORTS
//  CLK           in   1         clock
//  nRST          in   1         reset, synchronous, active-low
//  to_enq_v      in   WIDTH     word to send to host
//  to_enq_ena    in   1         push request; honoured only when to_enq_rdy is 1
//  to_enq_rdy    out  1         tx FIFO not full
//  from_enq_v    out  WIDTH     word received from host; 0 when from_enq_ena is 0
//  from_enq_ena  out  1         received word valid
//  from_enq_rdy  in   1         consumer accepts the word this cycle
//  jtag_sel      in   1         this user chain is selected
//  jtag_capture  in   1         CAPTURE-DR pulse
//  jtag_shift    in   1         one DR shift pulse (one bit)
//  jtag_update   in   1         UPDATE-DR pulse
//  jtag_tdi      in   1         serial in, sampled on a shift pulse
//  jtag_tdo      out  1         serial out, always equal to shreg[0]
// BEHAVIOUR
//  - Reset: FIFO empty, to_enq_rdy=1, shreg=0, jtag_tdo=0, bitcnt=0, rx_full=0,
//    from_enq_ena=0, from_enq_v=0.
//  - Push:
//    - to_enq_ena && to_enq_rdy writes the FIFO tail on that cycle.
//    - to_enq_rdy is !full, registered; a pop in the same cycle does not raise it.
//  - Strobes act only when jtag_sel=1. Priority when several pulse at once:
//    capture > update > shift.
//  - Capture:
//    - shreg[WIDTH:0] <= {head, 1'b1} and the head is popped, when the FIFO is non-empty.
//    - shreg <= 0 when the FIFO is empty.
//    - bitcnt <= 0.
//    - A push in the same cycle into an empty FIFO is not seen by this capture.
//  - Shift:
//    - shreg <= {jtag_tdi, shreg[WIDTH:1]}.
//    - bitcnt saturates at WIDTH+2.
//  - Update:
//    - Frame is valid iff bitcnt == WIDTH+1 and shreg[0] == 1.
//    - Valid frame with rx_full=0: rx_word <= shreg[WIDTH:1] and rx_full <= 1.
//    - Valid frame with rx_full=1 (the handshake has not completed): the frame is dropped
//      and rx_word is kept.
//    - bitcnt != WIDTH+1 (short or long frame): the frame is discarded.
//  - Rx handshake:
//    - from_enq_ena = rx_full.
//    - rx_full clears on the cycle after from_enq_ena && from_enq_rdy.
//    - An update in the clearing cycle sees rx_full=1 and is dropped.
//  - A popped tx word is lost if the host never completes the shift; there is no retransmit.
//  - Latency:
//    - push to capturable: 1 cycle.
//    - update to from_enq_ena: 1 cycle.
//  - Reset mid-frame aborts the frame, empties the FIFO and clears rx_full.
//  - FIFO pointers are log2(DEPTH)+1 bits and wrap modulo 2*DEPTH.
// CONFIGURATION
//  BSCAN_BRIDGE_STATS_EN
//  - Defined:
//    - Adds outputs stat_tx[7:0] (words captured), stat_rx[7:0] (words delivered),
//      stat_drop[7:0] (frames dropped or discarded).
//    - All three reset to 0 and wrap 255 -> 0.
//  - Undefined: the ports and counters are absent; all other behaviour is identical.
// TESTING
//  1. Reset, push 0xDEADBEEF, capture, 33 shifts with TDI=0 -> TDO stream LSB first: 1, then
//     0xDEADBEEF LSB-first; after capture the FIFO is empty.
//  2. Capture with FIFO empty, shift in {0x12345678,1}, update -> from_enq_ena=1 after
//     1 cycle, from_enq_v=0x12345678; rdy=1 -> ena=0 on the next cycle.
//  3. Push 4 words -> to_enq_rdy=0; 5th push ignored; 4 capture/shift frames return the
//     words in order; rdy=1 after the first pop.
//  4. Rx word pending with from_enq_rdy=0, second valid frame updated -> first word
//     retained; with STATS_EN, stat_drop=1.
//  5. Frame of 20 shifts then update -> no from_enq_ena; same with jtag_sel=0 and 33 shifts
//     -> no state change at all.
//  6. nRST low during shift bit 10 -> next frame captures valid=0, TDO=0, rx empty.

Source files
------------

// File: rtl/bscan_word_bridge.sv
// -----------------------------------------------------------------------------
// bscan_word_bridge
//
// Purpose:
//   Word-level bridge between 32-bit application pipes and a JTAG BSCAN user-DR
//   chain.
//   - Outgoing words are buffered in a small FIFO.
//   - On CAPTURE-DR the head word is loaded into the DR as {word, 1'b1}. The
//     low bit is a "valid" marker, and the frame is then shifted out on TDO,
//     LSB first.
//   - Bits shifted in from TDI form the host's frame. On UPDATE-DR a
//     well-formed frame is handed to the fromBscan pipe.
//   - JTAG strobes arrive as 1-cycle pulses that are already synchronous to
//     CLK, so the whole block is one clock domain.
//
// Parameters:
//   WIDTH  data word width. A DR frame is WIDTH+1 bits.
//   DEPTH  tx FIFO depth in words. Must be a power of two and >= 2.
//
// Ports:
//   CLK, nRST                  clock; synchronous active-low reset
//   to_enq_v/ena/rdy           word push into the tx FIFO
//                              (rdy = FIFO not full, registered)
//   from_enq_v/ena/rdy         received host word, valid/ready handshake
//   jtag_sel                   this user chain is selected (gates all strobes)
//   jtag_capture/shift/update  DR state pulses; priority capture > update > shift
//   jtag_tdi, jtag_tdo         serial in / serial out (tdo = shreg[0])
//
// Optional feature (macro BSCAN_BRIDGE_STATS_EN):
//   Adds the wrapping 8-bit counters stat_tx (words captured), stat_rx (words
//   delivered) and stat_drop (frames dropped or discarded).
// -----------------------------------------------------------------------------
module bscan_word_bridge #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [WIDTH-1:0] to_enq_v,
  input  logic             to_enq_ena,
  output logic             to_enq_rdy,
  output logic [WIDTH-1:0] from_enq_v,
  output logic             from_enq_ena,
  input  logic             from_enq_rdy,
  input  logic             jtag_sel,
  input  logic             jtag_capture,
  input  logic             jtag_shift,
  input  logic             jtag_update,
  input  logic             jtag_tdi,
  output logic             jtag_tdo
`ifdef BSCAN_BRIDGE_STATS_EN
  ,
  output logic [7:0]       stat_tx,
  output logic [7:0]       stat_rx,
  output logic [7:0]       stat_drop
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;              // extra wrap bit tells full from empty
  localparam int CW = $clog2(WIDTH + 3);   // bit counter must hold 0..WIDTH+2
  localparam logic [CW-1:0] CNT_FRAME = CW'(WIDTH + 1);
  localparam logic [CW-1:0] CNT_SAT   = CW'(WIDTH + 2);
  localparam logic [PW-1:0] PTR_FULL  = PW'(DEPTH);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             rdy_q, rdy_d;
  logic [WIDTH:0]   shreg_q, shreg_d;
  logic [CW-1:0]    bitcnt_q, bitcnt_d;
  logic             rx_full_q, rx_full_d;
  logic [WIDTH-1:0] rx_word_q, rx_word_d;

  // ---------------------------------------------------------------------------
  // Strobe decode. The priority is applied here, so the datapath below only
  // ever sees one active strobe.
  // ---------------------------------------------------------------------------
  logic do_capture, do_update, do_shift;
  logic fifo_empty, do_push, do_pop;
  logic frame_ok, rx_take, rx_drop, rx_deliver;
  logic [WIDTH-1:0] head_word;
  logic [PW-1:0]    occ_d;

  always_comb begin
    do_capture = jtag_sel && jtag_capture;
    do_update  = jtag_sel && jtag_update && !jtag_capture;
    do_shift   = jtag_sel && jtag_shift && !jtag_capture && !jtag_update;
  end

  // ---------------------------------------------------------------------------
  // tx FIFO.
  // - Capture reads the head from the current pointers, so a word pushed in the
  //   same cycle is not visible to that capture.
  // - rdy_q mirrors "not full" of the updated pointers. It is therefore always
  //   exact for the current contents, and a same-cycle pop cannot raise it
  //   early.
  // ---------------------------------------------------------------------------
  always_comb begin
    fifo_empty = (wr_ptr_q == rd_ptr_q);
    head_word  = mem_q[rd_ptr_q[AW-1:0]];
    do_push    = to_enq_ena && rdy_q;
    do_pop     = do_capture && !fifo_empty;
    wr_ptr_d   = wr_ptr_q + PW'(do_push);
    rd_ptr_d   = rd_ptr_q + PW'(do_pop);
    occ_d      = wr_ptr_d - rd_ptr_d;
    rdy_d      = (occ_d != PTR_FULL);
  end

  always_ff @(posedge CLK) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= to_enq_v;
    end
  end

  // ---------------------------------------------------------------------------
  // DR shift register, bit counter and rx holding register.
  // A frame is accepted only if:
  //   - exactly WIDTH+1 bits were shifted, and
  //   - the marker bit (now at shreg[0]) is 1.
  // ---------------------------------------------------------------------------
  always_comb begin
    shreg_d    = shreg_q;
    bitcnt_d   = bitcnt_q;
    rx_word_d  = rx_word_q;
    rx_full_d  = rx_full_q;

    frame_ok   = (bitcnt_q == CNT_FRAME) && shreg_q[0];
    rx_take    = do_update && frame_ok && !rx_full_q;
    rx_drop    = do_update && !rx_take;
    rx_deliver = rx_full_q && from_enq_rdy;

    if (do_capture) begin
      shreg_d  = fifo_empty ? '0 : {head_word, 1'b1};
      bitcnt_d = '0;
    end else if (do_shift) begin
      shreg_d = {jtag_tdi, shreg_q[WIDTH:1]};
      if (bitcnt_q != CNT_SAT) begin
        bitcnt_d = bitcnt_q + 1'b1;
      end
    end

    if (rx_take) begin
      rx_word_d = shreg_q[WIDTH:1];
    end

    // rx_take requires !rx_full_q, so it can never coincide with a delivery.
    // An update in the clearing cycle still sees rx_full_q=1 and is dropped.
    if (rx_deliver) begin
      rx_full_d = 1'b0;
    end else if (rx_take) begin
      rx_full_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      rdy_q     <= 1'b1;
      shreg_q   <= '0;
      bitcnt_q  <= '0;
      rx_full_q <= 1'b0;
      rx_word_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      rdy_q     <= rdy_d;
      shreg_q   <= shreg_d;
      bitcnt_q  <= bitcnt_d;
      rx_full_q <= rx_full_d;
      rx_word_q <= rx_word_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    to_enq_rdy   = rdy_q;
    jtag_tdo     = shreg_q[0];
    from_enq_ena = rx_full_q;
    from_enq_v   = rx_full_q ? rx_word_q : '0;
  end

`ifdef BSCAN_BRIDGE_STATS_EN
  // ---------------------------------------------------------------------------
  // Statistics counters. They wrap naturally at 8 bits.
  // ---------------------------------------------------------------------------
  logic [7:0] stat_tx_q, stat_tx_d;
  logic [7:0] stat_rx_q, stat_rx_d;
  logic [7:0] stat_drop_q, stat_drop_d;

  always_comb begin
    stat_tx_d   = stat_tx_q + 8'(do_pop);
    stat_rx_d   = stat_rx_q + 8'(rx_deliver);
    stat_drop_d = stat_drop_q + 8'(rx_drop);
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      stat_tx_q   <= '0;
      stat_rx_q   <= '0;
      stat_drop_q <= '0;
    end else begin
      stat_tx_q   <= stat_tx_d;
      stat_rx_q   <= stat_rx_d;
      stat_drop_q <= stat_drop_d;
    end
  end

  always_comb begin
    stat_tx   = stat_tx_q;
    stat_rx   = stat_rx_q;
    stat_drop = stat_drop_q;
  end
`endif

endmodule
